// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and March element tables
// for the memory BIST engine.
package mbist_pkg;

    typedef enum logic [1:0] {W0, W1, R0, R1} op_t;
    typedef enum logic {UP, DOWN} dir_t;

    localparam logic [1:0] ALG_MATS      = 2'd0;
    localparam logic [1:0] ALG_MARCH_X   = 2'd1;
    localparam logic [1:0] ALG_MARCH_CM  = 2'd2;
    localparam logic [1:0] ALG_WR_TOGGLE = 2'd3;

    typedef struct packed {
        dir_t       dir;
        logic [2:0] nops;
        op_t [0:3]  ops;
    } elem_t;

    function automatic dir_t elem_dir(input logic [1:0] alg,
                                      input logic [2:0] elem);
        dir_t d;
        d = UP;
        case (alg)
            ALG_MATS, ALG_MARCH_X: if (elem == 3'd2) d = DOWN;
            ALG_MARCH_CM: if (elem == 3'd3 || elem == 3'd4) d = DOWN;
            default: d = UP;
        endcase
        return d;
    endfunction

    function automatic elem_t mk(input dir_t d, input logic [2:0] n,
                                 input op_t a, b, c, e);
        elem_t r;
        r.dir    = d;
        r.nops   = n;
        r.ops[0] = a;
        r.ops[1] = b;
        r.ops[2] = c;
        r.ops[3] = e;
        return r;
    endfunction

    function automatic elem_t elem_info(input logic [1:0] alg,
                                        input logic [2:0] elem);
        dir_t  d;
        elem_t r;
        d = elem_dir(alg, elem);
        r = mk(d, 3'd1, W0, W0, W0, W0);
        case (alg)
            ALG_MATS: begin
                case (elem)
                    3'd1: r = mk(d, 3'd2, R0, W1, W0, W0);
                    3'd2: r = mk(d, 3'd2, R1, W0, W0, W0);
                    default: ;
                endcase
            end
            ALG_MARCH_X: begin
                case (elem)
                    3'd1: r = mk(d, 3'd2, R0, W1, W0, W0);
                    3'd2: r = mk(d, 3'd2, R1, W0, W0, W0);
                    3'd3: r = mk(d, 3'd1, R0, W0, W0, W0);
                    default: ;
                endcase
            end
            ALG_MARCH_CM: begin
                case (elem)
                    3'd1: r = mk(d, 3'd2, R0, W1, W0, W0);
                    3'd2: r = mk(d, 3'd2, R1, W0, W0, W0);
                    3'd3: r = mk(d, 3'd2, R0, W1, W0, W0);
                    3'd4: r = mk(d, 3'd2, R1, W0, W0, W0);
                    3'd5: r = mk(d, 3'd1, R0, W0, W0, W0);
                    default: ;
                endcase
            end
            default: r = mk(d, 3'd4, W0, R0, W1, R1);
        endcase
        return r;
    endfunction

    function automatic logic [2:0] elem_count(input logic [1:0] alg);
        logic [2:0] n;
        case (alg)
            ALG_MATS:     n = 3'd3;
            ALG_MARCH_X:  n = 3'd4;
            ALG_MARCH_CM: n = 3'd6;
            default:      n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: DEPTH-bounded up/down address counter.
// Direction is latched on load; last flags the terminal address.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dir,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

    dir_t cur_dir;

    // Load the start address of a new element or step one word
    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            cur_dir <= UP;
        end else if (load) begin
            cur_dir <= dir_t'(dir);
            addr    <= (dir_t'(dir) == UP) ? '0 : TOP;
        end else if (step) begin
            addr <= (cur_dir == UP) ? addr + 1'b1 : addr - 1'b1;
        end
    end

    assign last = (cur_dir == UP) ? (addr == TOP) : (addr == '0);

endmodule

// File: rtl/mbist_march_engine.sv
// mbist_march_engine: March BIST sequencer with port mux,
// one-deep read compare pipe and fail log.
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        alg_sel,
    input  logic              bg_sel,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_wdata,
    input  logic              func_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [2:0]        first_fail_elem,
    output logic [DATA_W-1:0] first_fail_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    logic [1:0]        alg;
    logic              bg;
    logic [2:0]        elem;
    logic [1:0]        op_idx;
    elem_t             cur;
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic              addr_last;
    logic              accept;
    logic              running;
    logic              op_end;
    logic              elem_end;
    logic              alg_end;
    logic              addr_load;
    logic              addr_step;
    dir_t              gen_dir;
    logic [DATA_W-1:0] bgd;
    logic [DATA_W-1:0] data;
    logic              eng_we;
    logic              is_read;
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;
    logic              miscmp;

    mbist_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr (
        .clk  (clk),
        .rst  (rst),
        .load (addr_load),
        .dir  (gen_dir),
        .step (addr_step),
        .addr (addr),
        .last (addr_last)
    );

    // Sequencer decode: current op, end-of-element/algorithm, data
    always_comb begin
        accept    = start && (state == IDLE || state == DONE);
        running   = (state == RUN);
        cur       = elem_info(alg, elem);
        op        = cur.ops[op_idx];
        op_end    = ({1'b0, op_idx} == cur.nops - 3'd1);
        elem_end  = op_end && addr_last;
        alg_end   = elem_end && (elem == elem_count(alg) - 3'd1);
        addr_step = running && op_end && !addr_last;
        addr_load = accept || (running && elem_end && !alg_end);
        gen_dir   = cur.dir;
        if (accept)
            gen_dir = elem_dir(alg_sel, 3'd0);
        else if (elem_end)
            gen_dir = elem_dir(alg, elem + 3'd1);
        for (int i = 0; i < DATA_W; i++)
            bgd[i] = bg & (i[0] ^ addr[0]);
        data    = (op == W1 || op == R1) ? ~bgd : bgd;
        eng_we  = running && (op == W0 || op == W1);
        is_read = running && (op == R0 || op == R1);
        miscmp  = cmp_valid && (mem_rdata != cmp_exp);
    end

    // Memory port mux; writes are blocked while in reset
    always_comb begin
        mem_addr  = busy ? addr : func_addr;
        mem_wdata = busy ? data : func_wdata;
        mem_we    = !rst && (busy ? eng_we : func_we);
    end

    // Control FSM with element and op pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            alg    <= '0;
            bg     <= 1'b0;
            elem   <= '0;
            op_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        alg    <= alg_sel;
                        bg     <= bg_sel;
                        elem   <= '0;
                        op_idx <= '0;
                    end
                end
                RUN: begin
                    if (op_end) begin
                        op_idx <= '0;
                        if (alg_end)
                            state <= DRAIN;
                        else if (addr_last)
                            elem <= elem + 3'd1;
                    end else begin
                        op_idx <= op_idx + 2'd1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read compare pipe and saturating fail log
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid       <= 1'b0;
            cmp_exp         <= '0;
            cmp_addr        <= '0;
            cmp_elem        <= '0;
            fail            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
            first_fail_data <= '0;
        end else begin
            cmp_valid <= is_read;
            if (is_read) begin
                cmp_exp  <= data;
                cmp_addr <= addr;
                cmp_elem <= elem;
            end
            if (accept) begin
                fail            <= 1'b0;
                fail_count      <= '0;
                first_fail_addr <= '0;
                first_fail_elem <= '0;
                first_fail_data <= '0;
            end else if (miscmp) begin
                fail <= 1'b1;
                if (fail_count != CNT_MAX)
                    fail_count <= fail_count + 1'b1;
                if (fail_count == '0) begin
                    first_fail_addr <= cmp_addr;
                    first_fail_elem <= cmp_elem;
                    first_fail_data <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_engine.sv
// tb_mbist_march_engine: directed runs against an SRAM model
// with injectable faults; results checked through a scoreboard.
module tb_mbist_march_engine;

    localparam int AW    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 3;

    typedef struct {
        int done_cyc;
        int busy_n;
        int fail;
        int cnt;
        int faddr;
        int felem;
        int fdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    alg_sel;
    logic          bg_sel;
    logic [AW-1:0] func_addr;
    logic [DW-1:0] func_wdata;
    logic          func_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          fail;
    logic [CW-1:0] fail_count;
    logic [AW-1:0] first_fail_addr;
    logic [2:0]    first_fail_elem;
    logic [DW-1:0] first_fail_data;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   c0     = 0;
    int   busy_n = 0;
    int   fault  = 0;
    logic done_q = 1'b0;
    exp_t sb[$];
    exp_t e_m;
    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    mbist_march_engine #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .alg_sel         (alg_sel),
        .bg_sel          (bg_sel),
        .func_addr       (func_addr),
        .func_wdata      (func_wdata),
        .func_we         (func_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .done            (done),
        .fail            (fail),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_elem (first_fail_elem),
        .first_fail_data (first_fail_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read; fault 1 = bit 2 of word 5 stuck at 1,
    // fault 2 = every read returns the inverted word
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (fault == 1)
            mem_rdata <= mem[mem_addr] | ((mem_addr == 8'd5) ? 4'b0100 : 4'b0000);
        else if (fault == 2)
            mem_rdata <= ~mem[mem_addr];
        else
            mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on each rising done, pop the expected run result and compare
    always @(negedge clk) begin
        if (busy) busy_n++;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc - c0 + 1);
            end else begin
                e_m = sb.pop_front();
                check("done_cycle", cyc - c0 + 1, e_m.done_cyc);
                check("busy_cycles", busy_n, e_m.busy_n);
                check("busy_at_done", busy, 0);
                check("fail", fail, e_m.fail);
                check("fail_count", fail_count, e_m.cnt);
                check("first_fail_addr", first_fail_addr, e_m.faddr);
                check("first_fail_elem", first_fail_elem, e_m.felem);
                check("first_fail_data", first_fail_data, e_m.fdata);
            end
        end
        done_q = done;
    end

    task automatic run(input logic [1:0] alg, input logic bg, input int fm,
                       input int poke, input exp_t e);
        int rel;
        fault   = fm;
        alg_sel = alg;
        bg_sel  = bg;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b1;
        c0     = cyc + 1;
        busy_n = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            rel   = cyc - c0 + 1;
            start = (rel == poke);
            if (alg == 2'd3 && bg) begin
                // w0 @1: B = i[0]^1 -> 0101; w1 @1: 1010; w0 @2: 1010
                if (rel == 5) begin
                    check("cb_w0_a1_addr", mem_addr, 1);
                    check("cb_w0_a1_we", mem_we, 1);
                    check("cb_w0_a1_data", mem_wdata, 4'b0101);
                end
                if (rel == 7) check("cb_w1_a1_data", mem_wdata, 4'b1010);
                if (rel == 9) begin
                    check("cb_w0_a2_addr", mem_addr, 2);
                    check("cb_w0_a2_data", mem_wdata, 4'b1010);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 400 cycles");
            void'(sb.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst        = 1'b1;
        start      = 1'b0;
        alg_sel    = 2'd0;
        bg_sel     = 1'b0;
        func_addr  = '0;
        func_wdata = '0;
        func_we    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_ff_addr", first_fail_addr, 0);
        check("rst_ff_elem", first_fail_elem, 0);
        check("rst_ff_data", first_fail_data, 0);

        func_addr  = 8'h3C;
        func_wdata = 4'h9;
        func_we    = 1'b1;
        #1;
        check("mux_addr", mem_addr, 8'h3C);
        check("mux_wdata", mem_wdata, 4'h9);
        check("mux_we", mem_we, 1);
        @(negedge clk);
        func_we = 1'b0;

        // MATS+ fault-free: N=80
        run(2'd0, 1'b0, 0, 0, '{82, 81, 0, 0, 0, 0, 0});
        // March C- with stuck-at-1 bit 2 @5: r0 fails in elems 1,3,5
        run(2'd2, 1'b0, 1, 0, '{162, 161, 1, 3, 5, 1, 4'b0100});
        // WR-toggle checkerboard fault-free: N=64
        run(2'd3, 1'b1, 0, 0, '{66, 65, 0, 0, 0, 0, 0});
        // March X every read fails: 48 reads saturate at 7
        run(2'd1, 1'b0, 2, 0, '{98, 97, 1, 7, 0, 1, 4'hF});
        // Same with checkerboard: first read expects 1010, sees 0101
        run(2'd1, 1'b1, 2, 0, '{98, 97, 1, 7, 0, 1, 4'b0101});

        // Reset in the middle of a failing run
        fault   = 2;
        alg_sel = 2'd0;
        bg_sel  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        c0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("midrun_fail_set", fail, 1);
        rst = 1'b1;
        #1;
        check("midrun_rst_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_fail", fail, 0);
        check("post_rst_fail_count", fail_count, 0);

        // MATS+ again from IDLE, with a start pulse at cycle 10 to ignore
        run(2'd0, 1'b0, 0, 10, '{82, 81, 0, 0, 0, 0, 0});

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
